// File: rtl/noc_pkg.sv
// Shared flit field positions, link state encodings and default link credit depth.
// Imported by the leaf uplink arbiter; holds no logic of its own.
package noc_pkg;

  localparam int DEST_GRP_MSB  = 15;
  localparam int DEST_GRP_LSB  = 12;
  localparam int DEST_LEAF_MSB = 11;
  localparam int DEST_LEAF_LSB = 10;

  localparam int DEF_CREDITS = 8;

  typedef enum logic [1:0] {
    LS_IDLE  = 2'b00,
    LS_SEND  = 2'b01,
    LS_STALL = 2'b10
  } link_state_e;

endpackage

// File: rtl/uplink_src_fifo.sv
// Per-source flit FIFO: pop data is combinational from the head, 0-cycle read latency.
// Full is derived from registered pointers only, so a push is refused while full even if a pop happens that cycle.
module uplink_src_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_push_dat,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_pop_dat,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop && !o_empty) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

endmodule

// File: rtl/leaf_uplink_arbiter.sv
// Round-robin uplink from NUM_SRC buffered leaf sources onto a valid-only spine link; 2 edges handshake to output.
// Link backpressure is a credit counter returned by credit_in pulses; sources are throttled only by FIFO full.
module leaf_uplink_arbiter
  import noc_pkg::*;
#(
  parameter int DWIDTH         = 16,
  parameter int NUM_SRC        = 4,
  parameter int SRC_FIFO_DEPTH = 4,
  parameter int CREDITS        = DEF_CREDITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           link_en,
  input  logic [NUM_SRC*DWIDTH-1:0]      src_data,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [DWIDTH-1:0]              up_out_data,
  output logic                           up_out_valid,
  input  logic                           credit_in,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic [1:0]                     link_state,
  output logic                           credit_err,
  output logic [15:0]                    sent_count
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [DWIDTH-1:0]  w_fifo_dat [NUM_SRC];

  logic [SW-1:0]      r_rr;
  logic [SW-1:0]      w_win;
  logic [SW-1:0]      w_idx;
  logic [SW-1:0]      w_rr_nxt;
  logic               w_found;
  logic               w_any;
  logic               w_grant;
  logic               w_stall;

  logic [DWIDTH-1:0]  r_out_dat;
  logic               r_out_vld;
  logic [CW-1:0]      r_credit;
  logic               r_credit_err;
  logic [15:0]        r_sent;
  link_state_e        r_state;

  assign src_ready = ~w_full;
  assign w_push    = src_valid & ~w_full;

  genvar g;
  for (g = 0; g < NUM_SRC; g++) begin : g_src
    uplink_src_fifo #(
      .DWIDTH(DWIDTH),
      .DEPTH (SRC_FIFO_DEPTH)
    ) u_fifo (
      .i_clk     (clk),
      .i_reset_n (reset),
      .i_push    (w_push[g]),
      .i_push_dat(src_data[g*DWIDTH +: DWIDTH]),
      .i_pop     (w_pop[g]),
      .o_pop_dat (w_fifo_dat[g]),
      .o_full    (w_full[g]),
      .o_empty   (w_empty[g])
    );
  end

  // First non-empty source at or after the rr pointer, wrapping modulo NUM_SRC.
  always_comb begin
    w_win   = r_rr;
    w_idx   = r_rr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = SW'((int'(r_rr) + k) % NUM_SRC);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_any    = |(~w_empty);
  assign w_grant  = link_en && (r_credit != '0) && w_any;
  assign w_stall  = link_en && w_any && (r_credit == '0);
  assign w_rr_nxt = (w_win == SW'(NUM_SRC - 1)) ? '0 : w_win + SW'(1);
  assign w_pop    = w_grant ? (NUM_SRC'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_dat    <= '0;
      r_out_vld    <= 1'b0;
      r_credit     <= CW'(CREDITS);
      r_credit_err <= 1'b0;
      r_sent       <= '0;
      r_rr         <= '0;
      r_state      <= LS_IDLE;
    end else begin
      r_out_vld <= w_grant;
      if (w_grant) begin
        r_out_dat <= w_fifo_dat[w_win];
        r_rr      <= w_rr_nxt;
        r_sent    <= r_sent + 16'd1;
      end

      // A returned credit and a grant in the same cycle cancel out.
      case ({w_grant, credit_in})
        2'b10: r_credit <= r_credit - CW'(1);
        2'b01: begin
          if (r_credit == CW'(CREDITS)) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credit <= r_credit + CW'(1);
          end
        end
        default: r_credit <= r_credit;
      endcase

      case (r_state)
        LS_IDLE: begin
          if (w_grant)      r_state <= LS_SEND;
          else if (w_stall) r_state <= LS_STALL;
        end
        LS_SEND: begin
          if (w_grant)      r_state <= LS_SEND;
          else if (w_stall) r_state <= LS_STALL;
          else              r_state <= LS_IDLE;
        end
        LS_STALL: begin
          if (w_grant)       r_state <= LS_SEND;
          else if (!w_stall) r_state <= LS_IDLE;
        end
        default: r_state <= LS_IDLE;
      endcase
    end
  end

  assign up_out_data  = r_out_dat;
  assign up_out_valid = r_out_vld;
  assign credit_cnt   = r_credit;
  assign credit_err   = r_credit_err;
  assign sent_count   = r_sent;
  assign link_state   = r_state;

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// Directed bench for leaf_uplink_arbiter: expected flits are queued as stimulus is driven
// and popped by a negedge monitor; state and counters are checked inline.
module tb_leaf_uplink_arbiter;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        link_en;
  logic [63:0] src_data;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic [15:0] up_out_data;
  logic        up_out_valid;
  logic        credit_in;
  logic [3:0]  credit_cnt;
  logic [1:0]  link_state;
  logic        credit_err;
  logic [15:0] sent_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          acc;
  bit          ok;
  logic [15:0] d;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  leaf_uplink_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .link_en     (link_en),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .up_out_data (up_out_data),
    .up_out_valid(up_out_valid),
    .credit_in   (credit_in),
    .credit_cnt  (credit_cnt),
    .link_state  (link_state),
    .credit_err  (credit_err),
    .sent_count  (sent_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [15:0] v);
    src_data[s*16 +: 16] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid flit must match the oldest expected entry.
  logic [15:0] mon_exp;
  always @(negedge clk) begin
    if (up_out_valid === 1'b1) begin
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_flit observed=%0h expected=none", up_out_data);
      end
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        n_vec++;
        assert (up_out_data === mon_exp) else begin
          n_err++;
          $error("FAIL flit_order observed=%0h expected=%0h", up_out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; link_en = 1'b0; credit_in = 1'b0; src_valid = '0; src_data = '0;
    tick; tick;
    reset = 1'b1;
    tick;
    chk("rst_valid", up_out_valid, 0);
    chk("rst_credit", credit_cnt, 8);
    chk("rst_ready", src_ready, 4'hF);
    chk("rst_state", link_state, LS_IDLE);
    chk("rst_sent", sent_count, 0);
    chk("rst_err", credit_err, 0);

    // Single flit from source 2: visible exactly two edges after the handshake.
    link_en = 1'b1;
    set_src(2, 16'h8A55);
    src_valid = 4'b0100;
    exp_q.push_back(16'h8A55);
    tick;
    src_valid = '0;
    chk("lat_not_early", up_out_valid, 0);
    tick;
    chk("single_valid", up_out_valid, 1);
    chk("single_data", up_out_data, 16'h8A55);
    chk("single_credit", credit_cnt, 7);
    chk("single_sent", sent_count, 1);
    chk("single_state", link_state, LS_SEND);
    tick;
    chk("single_one_cycle", up_out_valid, 0);
    chk("single_hold", up_out_data, 16'h8A55);
    chk("single_idle", link_state, LS_IDLE);

    // Two flits per source plus a third in src0; credits run out after eight.
    reset = 1'b0; link_en = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) begin
        d = 16'hC000 + 16'(s * 256) + 16'(r);
        set_src(s, d);
        exp_q.push_back(d);
      end
      src_valid = 4'hF;
      tick;
      src_valid = '0;
    end
    set_src(0, 16'hCE00);
    src_valid = 4'b0001;
    tick;
    src_valid = '0;
    link_en = 1'b1;
    repeat (8) tick;
    chk("rr_credit_zero", credit_cnt, 0);
    chk("rr_sent8", sent_count, 8);
    repeat (3) tick;
    chk("rr_stall_state", link_state, LS_STALL);
    chk("rr_stall_sent", sent_count, 8);
    chk("rr_drained", exp_q.size(), 0);
    exp_q.push_back(16'hCE00);
    credit_in = 1'b1;
    tick;
    credit_in = 1'b0;
    chk("zero_credit_no_grant", up_out_valid, 0);
    chk("credit_back", credit_cnt, 1);
    tick;
    chk("stall_release_valid", up_out_valid, 1);
    chk("stall_release_data", up_out_data, 16'hCE00);
    chk("stall_release_credit", credit_cnt, 0);
    repeat (2) tick;
    chk("after_release_state", link_state, LS_IDLE);
    chk("after_release_sent", sent_count, 9);

    // Credit returned in the grant cycle, then overflow at full credits.
    credit_in = 1'b1;
    repeat (5) tick;
    credit_in = 1'b0;
    chk("credit_five", credit_cnt, 5);
    set_src(1, 16'h5111);
    src_valid = 4'b0010;
    exp_q.push_back(16'h5111);
    tick;
    src_valid = '0;
    credit_in = 1'b1;
    tick;
    credit_in = 1'b0;
    chk("coincident_valid", up_out_valid, 1);
    chk("coincident_credit", credit_cnt, 5);
    credit_in = 1'b1;
    repeat (3) tick;
    credit_in = 1'b0;
    chk("credit_full", credit_cnt, 8);
    chk("credit_err_clear", credit_err, 0);
    credit_in = 1'b1;
    tick;
    credit_in = 1'b0;
    chk("credit_saturate", credit_cnt, 8);
    chk("credit_err_set", credit_err, 1);
    repeat (3) tick;
    chk("credit_err_sticky", credit_err, 1);

    // Source 1 pushes continuously with the link off until its FIFO fills.
    link_en = 1'b0;
    acc = 0;
    src_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      d = 16'h7000 + 16'(acc);
      set_src(1, d);
      ok = src_ready[1];
      tick;
      if (ok) begin
        exp_q.push_back(d);
        acc++;
      end
    end
    chk("fill_accepts", acc, 4);
    chk("fill_not_ready", src_ready[1], 0);
    link_en = 1'b1;
    tick;
    chk("ready_after_pop", src_ready[1], 1);
    exp_q.push_back(16'h7004);
    tick;
    src_valid = '0;
    repeat (6) tick;
    chk("fill_drained", exp_q.size(), 0);
    chk("fill_credit", credit_cnt, 3);
    chk("fill_sent", sent_count, 15);

    // Six flits queued; reset lands after three have gone out.
    link_en = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 3; s++) set_src(s, 16'h6000 + 16'(r * 16) + 16'(s));
      src_valid = 4'b0111;
      tick;
      src_valid = '0;
    end
    exp_q.push_back(16'h6002);
    exp_q.push_back(16'h6000);
    exp_q.push_back(16'h6001);
    link_en = 1'b1;
    repeat (3) tick;
    chk("pre_rst_sent", sent_count, 18);
    chk("pre_rst_data", up_out_data, 16'h6001);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("rst_mid_valid", up_out_valid, 0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("rst_flushed", up_out_valid, 0);
    end
    chk("rst_mid_credit", credit_cnt, 8);
    chk("rst_mid_sent", sent_count, 0);
    chk("rst_mid_state", link_state, LS_IDLE);
    chk("rst_mid_ready", src_ready, 4'hF);
    chk("rst_mid_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/leaf_uplink_arbiter.md
Name: leaf_uplink_arbiter

Overview:
- Leaf-side uplink stage that sits directly upstream of one spine router leaf port, for example spine41_in_data/spine41_in_valid.
- Collects single-flit packets from NUM_SRC local leaf sources, buffers each source in a small FIFO, and arbitrates round-robin onto the single valid-only spine link.
- The spine link has no ready signal, so this block enforces flow control with a credit counter sized to the spine port FIFO (8). Credits are returned by a per-flit credit pulse.

Parameters:
- DWIDTH, 16, flit width; [15:12] dest group, [11:10] dest leaf, [9:0] payload.
- NUM_SRC, 4, number of local sources (2..8).
- SRC_FIFO_DEPTH, 4, per-source FIFO depth (power of 2).
- CREDITS, 8, initial and maximum link credits; equals the spine port FIFO_DEPTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- link_en  in  1  1 = grants allowed; 0 = hold traffic in the FIFOs.
- src_data  in  NUM_SRC*DWIDTH  packed flits; source i occupies [i*DWIDTH +: DWIDTH].
- src_valid  in  NUM_SRC  per-source flit valid.
- src_ready  out  NUM_SRC  per-source ready; equals that source FIFO not full.
- up_out_data  out  DWIDTH  flit to the spine router leaf input.
- up_out_valid  out  1  one-cycle valid per flit.
- credit_in  in  1  one-cycle pulse; one spine FIFO slot freed.
- credit_cnt  out  $clog2(CREDITS+1)  current credits.
- link_state  out  2  00 IDLE, 01 SEND, 10 STALL.
- credit_err  out  1  sticky credit-overflow flag.
- sent_count  out  16  flits sent; wraps at 0xFFFF->0.

Behaviour:
- Reset (reset==0 at an edge) sets:
  - up_out_data=0, up_out_valid=0, credit_cnt=CREDITS, credit_err=0, sent_count=0.
  - link_state=IDLE, rr pointer=0, all FIFOs empty.
  - src_ready therefore reads all-ones once reset is released.
- Reset mid-operation discards all buffered flits; no partial flit is emitted afterwards.
- Source accept:
  - A flit is written when src_valid[i]&&src_ready[i].
  - src_ready[i] is combinational from FIFO full, registered state only.
  - A write while full is impossible by construction. Simultaneous pop and push on a full FIFO is still refused that cycle, since ready is not look-ahead.
- Grant, evaluated each cycle:
  - Grant only if link_en==1, registered credit_cnt>0, and any FIFO is non-empty.
  - The winner is the first non-empty source at or after rr pointer, searching upward modulo NUM_SRC.
  - On grant: pop the winner, register the flit onto up_out_data, up_out_valid=1 next cycle, rr pointer = winner+1 (mod NUM_SRC).
  - No grant: up_out_valid=0 and up_out_data holds its last value.
- Latency: flit written at edge E0 is in the FIFO after E0, granted at E1, and visible on up_out_* after E1. Minimum 2 edges from src handshake to output. Throughput is 1 flit/cycle with credits available.
- Credits:
  - Grant only: -1. credit_in only: +1. Both in the same cycle: unchanged.
  - credit_in with credit_cnt==CREDITS and no grant: count saturates, credit_err set until reset.
  - Grant never occurs at credit_cnt==0, even if credit_in is high that cycle; the credit is usable next cycle.
- sent_count increments on every grant, wrapping modulo 2^16.
- link_state is a registered FSM, evaluated on next-cycle inputs:
  - IDLE: no FIFO non-empty or link_en==0. Go to SEND when grant conditions hold; go to STALL when data is present, link_en==1 and credits==0.
  - SEND: a grant was issued this cycle. Go to STALL when credits reach 0 with data pending; go to IDLE when FIFOs are empty or link_en==0.
  - STALL: data pending, link_en==1, credits==0. Go to SEND on credit return; go to IDLE on link_en==0.
- link_en deasserted mid-stream: the flit already registered still completes its single valid cycle; no new grants are issued.

Decomposition:
- Package noc_pkg holds:
  - Flit field constants: DEST_GRP_MSB=15, DEST_GRP_LSB=12, DEST_LEAF_MSB=11, DEST_LEAF_LSB=10.
  - link_state encodings.
  - Default CREDITS=8.
- One sub-module: uplink_src_fifo, a synchronous FIFO with push/pop/full/empty and registered pointers plus one wrap bit. It is instantiated NUM_SRC times.
- Arbiter, credit counter and FSM stay in the top level.

Test Plan:
- Reset with all src_valid=0 -> up_out_valid=0, credit_cnt=8, src_ready=4'b1111, link_state=IDLE, sent_count=0.
- Source 2 sends 0x8A55 once, link_en=1 -> up_out_data=0x8A55 with valid for exactly 1 cycle, 2 edges after the handshake; credit_cnt=7, sent_count=1.
- All 4 sources hold 2 flits each, no credit_in -> output order is src0,1,2,3,0,1,2,3. After 8 flits credit_cnt=0, link_state=STALL, and nothing more is sent. One credit_in pulse -> exactly one more flit, from src0's next entry if refilled.
- credit_in coincident with a grant at credit_cnt=5 -> credit_cnt stays 5. credit_in at credit_cnt=8 with idle traffic -> credit_cnt=8 and credit_err=1 sticky.
- Source 1 pushes continuously with the link disabled -> after 4 accepts src_ready[1]=0. Enable link -> ready returns one cycle after the first pop.
- Reset asserted after 3 of 6 queued flits were sent -> no further up_out_valid, credit_cnt=8, sent_count=0.
